// File: rtl/tachometer_multi_pkg.sv
// Shared types and helpers for the multi-channel tachometer.
// Holds the edge-mode enum, sync depth and saturating add.
package tachometer_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_BOTH = 1'b1
  } edge_mode_e;

  // 32-bit saturating increment; caller truncates to its width
  function automatic logic [31:0] sat_add(
    input logic [31:0] cnt,
    input logic        inc,
    input int unsigned width
  );
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF
                        : ((32'd1 << width) - 32'd1);
    return (inc && (cnt < top)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/tachometer_multi_channel.sv
// One tachometer channel: synchroniser, edge detect,
// saturating window counter and latched result.
module tach_channel
  import tachometer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   system_reset,
  input  logic                   enable,
  input  logic                   both_edges,
  input  logic                   encoder_in,
  input  logic                   window_tick,
  output logic [COUNT_WIDTH-1:0] count_latched,
  output logic                   overflow
);

  logic [SYNC_STAGES:0]   pipe;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic                   sat;
  logic                   s2;
  logic                   s3;
  logic                   rise;
  logic                   fall;
  logic                   hit;
  logic                   full;
  edge_mode_e             mode;

  assign mode = edge_mode_e'(both_edges);
  assign s2   = pipe[SYNC_STAGES-1];
  assign s3   = pipe[SYNC_STAGES];
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign hit  = rise | ((mode == EDGE_BOTH) & fall);
  assign full = &cnt;

  assign cnt_next =
    COUNT_WIDTH'(sat_add(32'(cnt), hit, COUNT_WIDTH));

  // Synchroniser plus history flop; runs even when disabled
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-1:0], encoder_in};
    end
  end

  // Window counter; terminal-cycle edge joins closing window
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      cnt           <= '0;
      sat           <= 1'b0;
      count_latched <= '0;
      overflow      <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (window_tick) begin
      count_latched <= cnt_next;
      overflow      <= sat | (full & hit);
      cnt           <= '0;
      sat           <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (full & hit) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tachometer_multi.sv
// Multi-channel encoder tachometer over a shared gate window.
// Owns the window timer, valid strobe and output packing.
module tachometer_multi
  import tachometer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter int CLOCK_FREQ   = 100000000,
  parameter int GATE_HZ      = 1000
) (
  input  logic                                clock,
  input  logic                                system_reset,
  input  logic                                enable,
  input  logic                                both_edges,
  input  logic [NUM_CHANNELS-1:0]             encoder_in,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0]             overflow,
  output logic                                data_valid,
  output logic                                window_tick
);

  localparam int GATE_CLOCKS = CLOCK_FREQ / GATE_HZ;
  localparam int TW = $clog2(GATE_CLOCKS);
  localparam logic [TW-1:0] LAST = TW'(GATE_CLOCKS - 1);

  if (GATE_CLOCKS < 4) begin : g_gate_check
    $error("GATE_CLOCKS must be at least 4");
  end

  logic [TW-1:0] timer;

  assign window_tick = enable & (timer == LAST);

  // Gate timer; held at zero while disabled
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      timer <= '0;
    end else if (!enable || timer == LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Valid strobe follows the terminal cycle by one clock
  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= window_tick;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [COUNT_WIDTH-1:0] count_latched;

    tach_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clock        (clock),
      .system_reset (system_reset),
      .enable       (enable),
      .both_edges   (both_edges),
      .encoder_in   (encoder_in[i]),
      .window_tick  (window_tick),
      .count_latched(count_latched),
      .overflow     (overflow[i])
    );

    assign data_out[i*COUNT_WIDTH +: COUNT_WIDTH] = count_latched;
  end

endmodule
